// File: rtl/exec_writeback_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | exec_writeback_pkg : shared types for the execute writeback stage |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
package exec_writeback_pkg;

  localparam int unsigned C_RESULT_W = 64;
  localparam int unsigned C_REG_IDX_W = 5;
  localparam int unsigned C_RETIRED_W = 32;

  typedef logic [C_RESULT_W-1:0]  long_t;
  typedef logic [C_REG_IDX_W-1:0] reg_idx_t;

  // Bit order {z,n,c,sn}: z is the MSB, sn the LSB.
  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic sn;
  } flags_t;

  typedef struct packed {
    long_t    result;
    reg_idx_t rd;
    logic     wr_reg;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  function automatic flags_t pack_flags(input logic z, input logic n,
                                        input logic c, input logic sn);
    flags_t f;
    f.z  = z;
    f.n  = n;
    f.c  = c;
    f.sn = sn;
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/exec_writeback_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | exec_writeback_if : ALU-side and register-file-side bundle        |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
interface exec_writeback_if;
  import exec_writeback_pkg::*;

  logic     in_valid;
  logic     in_ready;
  long_t    in_result;
  logic     in_z;
  logic     in_n;
  logic     in_c;
  logic     in_sn;
  reg_idx_t in_rd;
  logic     in_wr_reg;
  logic     in_wr_flags;
  logic     flush;

  logic     out_valid;
  logic     out_ready;
  long_t    out_result;
  reg_idx_t out_rd;
  logic     out_wr_reg;

  flags_t                 flags;
  logic                   carry_fb;
  logic [C_RETIRED_W-1:0] retired;

  // master: the ALU / register file environment around the stage
  modport master (
    output in_valid, in_result, in_z, in_n, in_c, in_sn, in_rd,
           in_wr_reg, in_wr_flags, flush, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_wr_reg,
           flags, carry_fb, retired
  );

  modport slave (
    input  in_valid, in_result, in_z, in_n, in_c, in_sn, in_rd,
           in_wr_reg, in_wr_flags, flush, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_wr_reg,
           flags, carry_fb, retired
  );

endinterface
`default_nettype wire

// File: rtl/exec_writeback_skid_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | skid_buffer : two-entry FIFO skid buffer with registered ready    |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module skid_buffer
  import exec_writeback_pkg::*;
#(
  parameter type T = logic [7:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  skid_state_e state_q, state_d;
  T            head_q, head_d;
  T            tail_q, tail_d;
  logic        in_ready_q, in_ready_d;
  logic        push;
  logic        pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SKID_EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_comb begin
    push       = in_valid & in_ready_q & ~flush;
    pop        = (state_q != SKID_EMPTY) & out_ready;
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    unique case (state_q)
      SKID_EMPTY: begin
        if (push) begin
          head_d  = in_data;
          state_d = SKID_ONE;
        end
      end
      SKID_ONE: begin
        // Simultaneous push/pop replaces the head in place.
        if (push && pop) begin
          head_d = in_data;
        end else if (push) begin
          tail_d  = in_data;
          state_d = SKID_FULL;
        end else if (pop) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = SKID_ONE;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
    if (flush) begin
      state_d = SKID_EMPTY;
    end
    // Ready is a flop: it depends only on the state being entered.
    in_ready_d = (state_d != SKID_FULL);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != SKID_EMPTY);
  assign out_data  = head_q;

endmodule
`default_nettype wire

// File: rtl/exec_writeback.sv
`default_nettype none
// +------------------------------------------------------------------+
// | exec_writeback : result skid buffer, flags register, retire count |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module exec_writeback
  import exec_writeback_pkg::*;
(
  input logic             clk,
  input logic             rst,
  exec_writeback_if.slave wb
);

  wb_entry_t              in_entry;
  wb_entry_t              out_entry;
  logic                   accept;
  logic                   pop;
  flags_t                 flags_q, flags_d;
  logic [C_RETIRED_W-1:0] retired_q, retired_d;

  always_comb begin
    in_entry.result = wb.in_result;
    in_entry.rd     = wb.in_rd;
    in_entry.wr_reg = wb.in_wr_reg;
  end

  skid_buffer #(
    .T (wb_entry_t)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (wb.flush),
    .in_valid  (wb.in_valid),
    .in_ready  (wb.in_ready),
    .in_data   (in_entry),
    .out_valid (wb.out_valid),
    .out_ready (wb.out_ready),
    .out_data  (out_entry)
  );

  always_comb begin
    // Same acceptance rule as the buffer: flush drops the push.
    accept    = wb.in_valid & wb.in_ready & ~wb.flush;
    pop       = wb.out_valid & wb.out_ready;
    flags_d   = flags_q;
    if (accept && wb.in_wr_flags) begin
      flags_d = pack_flags(wb.in_z, wb.in_n, wb.in_c, wb.in_sn);
    end
    retired_d = retired_q + {{(C_RETIRED_W-1){1'b0}}, pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q   <= '0;
      retired_q <= '0;
    end else begin
      flags_q   <= flags_d;
      retired_q <= retired_d;
    end
  end

  assign wb.out_result = out_entry.result;
  assign wb.out_rd     = out_entry.rd;
  assign wb.out_wr_reg = out_entry.wr_reg;
  assign wb.flags      = flags_q;
  assign wb.carry_fb   = flags_q.c;
  assign wb.retired    = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_exec_writeback.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_exec_writeback : directed + random bench with entry scoreboard |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module tb_exec_writeback;
  import exec_writeback_pkg::*;

  logic clk;
  logic rst;
  exec_writeback_if bus();

  exec_writeback dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  wb_entry_t   q[$];
  flags_t      mflags;
  logic [31:0] mret;
  logic        last_push;

  task automatic chkw(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] res, input logic [4:0] rd,
                       input logic wrr, input logic wrf, input logic [3:0] f,
                       input logic ordy, input logic fl);
    bus.in_valid    = v;
    bus.in_result   = res;
    bus.in_rd       = rd;
    bus.in_wr_reg   = wrr;
    bus.in_wr_flags = wrf;
    bus.in_z        = f[3];
    bus.in_n        = f[2];
    bus.in_c        = f[1];
    bus.in_sn       = f[0];
    bus.out_ready   = ordy;
    bus.flush       = fl;
  endtask

  function automatic void model_reset();
    q.delete();
    mflags = '0;
    mret   = '0;
  endfunction

  // Check outputs against the model at the falling edge, then advance the
  // model by the handshakes that the coming rising edge will perform.
  task automatic tick();
    logic      push;
    logic      pop;
    wb_entry_t e;
    wb_entry_t h;
    @(negedge clk);
    chkb("out_valid", bus.out_valid, q.size() != 0);
    chkb("in_ready", bus.in_ready, q.size() != 2);
    chkw("flags", {60'd0, bus.flags}, {60'd0, mflags});
    chkb("carry_fb", bus.carry_fb, mflags.c);
    chkw("retired", {32'd0, bus.retired}, {32'd0, mret});
    if (q.size() != 0) begin
      h = q[0];
      chkw("out_result", bus.out_result, h.result);
      chkw("out_rd", {59'd0, bus.out_rd}, {59'd0, h.rd});
      chkb("out_wr_reg", bus.out_wr_reg, h.wr_reg);
    end
    pop  = (q.size() != 0) && bus.out_ready;
    push = bus.in_valid && (q.size() != 2) && !bus.flush;
    last_push = push;
    if (pop) begin
      void'(q.pop_front());
      mret = mret + 32'd1;
    end
    if (push) begin
      e.result = bus.in_result;
      e.rd     = bus.in_rd;
      e.wr_reg = bus.in_wr_reg;
      q.push_back(e);
      if (bus.in_wr_flags) mflags = {bus.in_z, bus.in_n, bus.in_c, bus.in_sn};
    end
    if (bus.flush) q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 64'd0, 5'd0, 1'b0, 1'b0, 4'd0, ordy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] base;
    int          n;
    rst = 1'b1;
    idle(1'b0);
    model_reset();
    last_push = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chkb("rst_out_valid", bus.out_valid, 1'b0);
    chkb("rst_in_ready", bus.in_ready, 1'b1);
    chkw("rst_out_result", bus.out_result, 64'd0);
    chkw("rst_out_rd", {59'd0, bus.out_rd}, 64'd0);
    chkb("rst_out_wr_reg", bus.out_wr_reg, 1'b0);
    chkw("rst_flags", {60'd0, bus.flags}, 64'd0);
    chkb("rst_carry_fb", bus.carry_fb, 1'b0);
    chkw("rst_retired", {32'd0, bus.retired}, 64'd0);
    rst = 1'b0;

    // Single push, popped the cycle after it appears; accepted at the first edge.
    drive(1'b1, 64'd5, 5'd3, 1'b1, 1'b1, 4'b0010, 1'b1, 1'b0);
    tick();
    chkb("first_accept", last_push, 1'b1);
    idle(1'b1);
    chkb("lat1_out_valid", bus.out_valid, 1'b1);
    chkw("lat1_out_result", bus.out_result, 64'd5);
    chkb("lat1_carry_fb", bus.carry_fb, 1'b1);
    tick();
    tick();
    chkw("retired_after_pop", {32'd0, bus.retired}, 64'd1);

    // Back-to-back A, B, C against a stalled consumer.
    base = mret;
    drive(1'b1, 64'hAAAA_0000_0000_000A, 5'd10, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 64'hBBBB_0000_0000_000B, 5'd11, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    chkb("in_ready_after_b", bus.in_ready, 1'b0);
    drive(1'b1, 64'hCCCC_0000_0000_000C, 5'd12, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    chkb("c_stalled", last_push, 1'b0);
    bus.out_ready = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_push && n < 8);
    chkb("c_accepted", last_push, 1'b1);
    idle(1'b1);
    n = 0;
    while (q.size() != 0 && n < 8) begin
      tick();
      n++;
    end
    chkw("drain_abc", {32'd0, bus.retired}, {32'd0, base + 32'd3});

    // Flags hold on a push without wr_flags.
    drive(1'b1, 64'd1, 5'd1, 1'b1, 1'b1, 4'b0010, 1'b1, 1'b0);
    tick();
    drive(1'b1, 64'd2, 5'd2, 1'b1, 1'b0, 4'b1000, 1'b1, 1'b0);
    tick();
    idle(1'b1);
    tick();
    chkw("flags_hold", {60'd0, bus.flags}, 64'h2);

    // Flush while FULL with a flag-writing push offered.
    drive(1'b1, 64'h11, 5'd4, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 64'h22, 5'd5, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 64'h33, 5'd6, 1'b1, 1'b1, 4'b1101, 1'b0, 1'b1);
    tick();
    idle(1'b0);
    chkb("flush_out_valid", bus.out_valid, 1'b0);
    chkb("flush_in_ready", bus.in_ready, 1'b1);
    chkw("flush_flags", {60'd0, bus.flags}, 64'h2);

    // Flush in ONE with a pop still counts the pop, drops the push.
    drive(1'b1, 64'h44, 5'd7, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    base = mret;
    drive(1'b1, 64'h55, 5'd8, 1'b1, 1'b1, 4'b1111, 1'b1, 1'b1);
    tick();
    idle(1'b0);
    chkw("flush_pop_retired", {32'd0, bus.retired}, {32'd0, base + 32'd1});
    chkw("flush_pop_flags", {60'd0, bus.flags}, 64'h2);
    tick();

    // Retired counter wraps.
    drive(1'b1, 64'h66, 5'd9, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    mret = 32'hFFFF_FFFF;
    idle(1'b1);
    tick();
    tick();
    chkw("retired_wrap", {32'd0, bus.retired}, 64'd0);

    // Asynchronous reset while FULL.
    drive(1'b1, 64'h77, 5'd13, 1'b1, 1'b1, 4'b1011, 1'b0, 1'b0);
    tick();
    drive(1'b1, 64'h88, 5'd14, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chkb("async_out_valid", bus.out_valid, 1'b0);
    chkw("async_flags", {60'd0, bus.flags}, 64'd0);
    chkb("async_carry_fb", bus.carry_fb, 1'b0);
    chkb("async_in_ready", bus.in_ready, 1'b1);
    chkw("async_retired", {32'd0, bus.retired}, 64'd0);
    model_reset();
    rst = 1'b0;
    drive(1'b1, 64'h99, 5'd15, 1'b1, 1'b1, 4'b0100, 1'b1, 1'b0);
    tick();
    chkb("post_reset_accept", last_push, 1'b1);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 1)), {$urandom, $urandom}, 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
      tick();
    end
    idle(1'b1);
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
